frame_capture_ctrl: RTL and testbench

Sequences single-frame captures from the camera sensor stream inside the IPU. A capture request arms the block, which skips a programmable number of whole frames and then gates pixel writes for exactly one complete frame, bounded by the FVAL edges. It also checks the frame geometry against the configured active size and reports completion and errors back to the requester. It sits between the sensor input (FVAL/LVAL) and the frame-buffer write port.

---
 rtl/ipu_pkg.sv | 6 +
 rtl/sync_edge_detect.sv | 16 +
 rtl/frame_capture_ctrl.sv | 104 ++++++++++
 tb/tb_frame_capture_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/ipu_pkg.sv
// ipu_pkg: shared capture-controller state encoding and default frame geometry
package ipu_pkg;
  typedef enum logic [1:0] {IDLE, ARM, CAPTURE, DONE} state_e;
  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;
endpackage

// File: rtl/sync_edge_detect.sv
// sync_edge_detect: registers a level and emits single-cycle rise/fall pulses
module sync_edge_detect (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);
  logic d_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) d_q <= 1'b0;
    else d_q <= d_i;
  end
  assign rise_o = d_i & ~d_q;
  assign fall_o = ~d_i & d_q;
endmodule

// File: rtl/frame_capture_ctrl.sv
// frame_capture_ctrl: arms on request, skips N frames, gates one whole frame and checks its geometry
module frame_capture_ctrl
  import ipu_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int SKIP_W   = 3,
  parameter int CNT_W    = 12
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iFVAL,
  input  logic              iLVAL,
  input  logic              iStart,
  input  logic [SKIP_W-1:0] iSkip,
  input  logic              iAbort,
  output logic              oBusy,
  output logic              oCapture_En,
  output logic              oDone,
  output logic              oErr,
  output logic [CNT_W-1:0]  oLine_cnt,
  output logic [CNT_W-1:0]  oPix_cnt
);
  state_e state_q, state_d;
  logic [SKIP_W-1:0] skip_q, skip_d;
  logic [CNT_W-1:0] line_q, line_d, pix_q, pix_d;
  logic err_q, err_d;
  logic sof, eof, eol, unused_lval_rise;
  sync_edge_detect u_fval (
    .clk_i (iCLK),
    .rst_i (iRST),
    .d_i   (iFVAL),
    .rise_o(sof),
    .fall_o(eof)
  );
  sync_edge_detect u_lval (
    .clk_i (iCLK),
    .rst_i (iRST),
    .d_i   (iLVAL),
    .rise_o(unused_lval_rise),
    .fall_o(eol)
  );
  // the first pixel of a frame can coincide with sof, so enable before CAPTURE is registered
  assign oCapture_En = iFVAL & iLVAL &
                       ((state_q == CAPTURE) | ((state_q == ARM) & sof & (skip_q == '0)));
  always_comb begin
    state_d = state_q;
    skip_d  = skip_q;
    line_d  = line_q;
    pix_d   = pix_q;
    err_d   = err_q;
    if (iAbort) state_d = IDLE;
    else begin
      case (state_q)
        IDLE: if (iStart) begin
          skip_d  = iSkip;
          line_d  = '0;
          pix_d   = '0;
          err_d   = 1'b0;
          state_d = ARM;
        end
        ARM: if (sof) begin
          if (skip_q == '0) state_d = CAPTURE;
          else skip_d = skip_q - 1'b1;
        end
        CAPTURE: begin
          if (eol) begin
            err_d  = err_q | (pix_q != CNT_W'(H_ACTIVE));
            pix_d  = '0;
            line_d = (line_q == '1) ? line_q : line_q + 1'b1;
          end
          // frame check sees the line count already updated by a coincident eol
          if (eof) begin
            err_d   = err_d | (line_d != CNT_W'(V_ACTIVE));
            state_d = DONE;
          end
        end
        DONE: state_d = IDLE;
        default: state_d = IDLE;
      endcase
      if (oCapture_En) pix_d = (pix_q == '1) ? pix_q : pix_q + 1'b1;
    end
  end
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q <= IDLE;
      skip_q  <= '0;
      line_q  <= '0;
      pix_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
      line_q  <= line_d;
      pix_q   <= pix_d;
      err_q   <= err_d;
    end
  end
  assign oBusy     = state_q != IDLE;
  assign oDone     = state_q == DONE;
  assign oErr      = err_q;
  assign oLine_cnt = line_q;
  assign oPix_cnt  = pix_q;
endmodule

// File: tb/tb_frame_capture_ctrl.sv
// tb_frame_capture_ctrl: directed frame sequences checked against a behavioural capture model
module tb_frame_capture_ctrl;
  localparam int H = 4;
  localparam int V = 3;
  localparam int CMAX = 4095;
  logic iCLK = 1'b0, iRST = 1'b1, iFVAL = 1'b0, iLVAL = 1'b0, iStart = 1'b0, iAbort = 1'b0;
  logic [2:0] iSkip = '0;
  logic oBusy, oCapture_En, oDone, oErr;
  logic [11:0] oLine_cnt, oPix_cnt;
  int n_cmp = 0, n_bad = 0, caps = 0, dones = 0;
  bit check_en = 1'b0;
  frame_capture_ctrl #(.H_ACTIVE(H), .V_ACTIVE(V), .SKIP_W(3), .CNT_W(12)) dut (
    .iCLK(iCLK), .iRST(iRST), .iFVAL(iFVAL), .iLVAL(iLVAL), .iStart(iStart),
    .iSkip(iSkip), .iAbort(iAbort), .oBusy(oBusy), .oCapture_En(oCapture_En),
    .oDone(oDone), .oErr(oErr), .oLine_cnt(oLine_cnt), .oPix_cnt(oPix_cnt)
  );
  always #5 iCLK = ~iCLK;
  task automatic cmp(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  // model: request -> wait out `left` whole frames -> take the next full frame -> report
  int m_mode = 0, m_left = 0, m_lines = 0, m_pix = 0;
  bit m_err = 0, pf = 0, pl = 0;
  always @(negedge iCLK) if (check_en) begin
    bit sof, eof, eol, e_cap;
    sof = iFVAL && !pf;
    eof = !iFVAL && pf;
    eol = !iLVAL && pl;
    e_cap = iFVAL && iLVAL && (m_mode == 2 || (m_mode == 1 && sof && m_left == 0));
    cmp("busy", 32'(oBusy), 32'(m_mode != 0));
    cmp("done", 32'(oDone), 32'(m_mode == 3));
    cmp("cap_en", 32'(oCapture_En), 32'(e_cap));
    cmp("err", 32'(oErr), 32'(m_err));
    cmp("line_cnt", 32'(oLine_cnt), 32'(m_lines));
    cmp("pix_cnt", 32'(oPix_cnt), 32'(m_pix));
    if (oCapture_En === 1'b1) caps++;
    if (oDone === 1'b1) dones++;
    if (iRST) begin
      m_mode = 0; m_left = 0; m_lines = 0; m_pix = 0; m_err = 0; pf = 0; pl = 0;
    end else begin
      pf = iFVAL;
      pl = iLVAL;
      if (iAbort) m_mode = 0;
      else begin
        if (m_mode == 0 && iStart) begin
          m_mode = 1; m_left = int'(iSkip); m_lines = 0; m_pix = 0; m_err = 0;
        end else if (m_mode == 1 && sof) begin
          if (m_left == 0) m_mode = 2;
          else m_left--;
        end else if (m_mode == 2) begin
          if (eol) begin
            if (m_pix != H) m_err = 1;
            m_pix = 0;
            m_lines = (m_lines < CMAX) ? m_lines + 1 : CMAX;
          end
          if (eof) begin
            if (m_lines != V) m_err = 1;
            m_mode = 3;
          end
        end else if (m_mode == 3) m_mode = 0;
        if (e_cap) m_pix = (m_pix < CMAX) ? m_pix + 1 : CMAX;
      end
    end
  end
  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask
  task automatic start(int skip);
    iStart = 1'b1;
    iSkip = 3'(skip);
    tick();
    iStart = 1'b0;
  endtask
  task automatic send_frame(int nl, int np, int long_idx, bit tight);
    iFVAL = 1'b1;
    tick(); tick();
    for (int i = 0; i < nl; i++) begin
      iLVAL = 1'b1;
      repeat (np + int'(i == long_idx)) tick();
      iLVAL = 1'b0;
      if (tight && i == nl - 1) iFVAL = 1'b0;
      tick(); tick();
    end
    iFVAL = 1'b0;
    repeat (3) tick();
  endtask
  task automatic expect_end(string tag, int ecaps, int edones, int eerr, int elines);
    cmp({tag, "_caps"}, 32'(caps), 32'(ecaps));
    cmp({tag, "_dones"}, 32'(dones), 32'(edones));
    cmp({tag, "_err"}, 32'(oErr), 32'(eerr));
    cmp({tag, "_lines"}, 32'(oLine_cnt), 32'(elines));
    caps = 0;
    dones = 0;
  endtask
  task automatic partial_two_lines();
    iFVAL = 1'b1;
    tick(); tick();
    iLVAL = 1'b1;
    repeat (4) tick();
    iLVAL = 1'b0;
    tick(); tick();
    iLVAL = 1'b1;
    tick(); tick();
  endtask
  task automatic finish_frame();
    tick();
    iLVAL = 1'b0;
    tick(); tick();
    iLVAL = 1'b1;
    repeat (4) tick();
    iLVAL = 1'b0;
    tick();
    iFVAL = 1'b0;
    repeat (3) tick();
  endtask
  initial begin
    tick();
    check_en = 1'b1;
    tick();
    iRST = 1'b0;
    tick();
    cmp("rst_busy", 32'(oBusy), 0);
    cmp("rst_done", 32'(oDone), 0);
    cmp("rst_cap", 32'(oCapture_En), 0);
    cmp("rst_err", 32'(oErr), 0);
    cmp("rst_line", 32'(oLine_cnt), 0);
    cmp("rst_pix", 32'(oPix_cnt), 0);
    start(0);
    cmp("start_busy", 32'(oBusy), 1);
    send_frame(3, 4, -1, 0);
    expect_end("basic", 12, 1, 0, 3);
    start(2);
    send_frame(3, 4, -1, 0);
    send_frame(3, 4, -1, 0);
    cmp("skip_early_caps", 32'(caps), 0);
    send_frame(3, 4, -1, 0);
    expect_end("skip", 12, 1, 0, 3);
    iFVAL = 1'b1;
    tick();
    start(0);
    iLVAL = 1'b1;
    repeat (4) tick();
    iLVAL = 1'b0;
    tick();
    iFVAL = 1'b0;
    tick(); tick();
    cmp("mid_ignored_caps", 32'(caps), 0);
    send_frame(3, 4, -1, 0);
    expect_end("midframe", 12, 1, 0, 3);
    start(0);
    send_frame(3, 4, 1, 0);
    cmp("long_pix", 32'(oPix_cnt), 0);
    expect_end("long_line", 13, 1, 1, 3);
    start(0);
    send_frame(2, 4, -1, 0);
    expect_end("short_frame", 8, 1, 1, 2);
    start(0);
    send_frame(3, 4, -1, 1);
    expect_end("eol_eof", 12, 1, 0, 3);
    start(0);
    partial_two_lines();
    iAbort = 1'b1;
    iStart = 1'b1;
    tick();
    iAbort = 1'b0;
    iStart = 1'b0;
    cmp("abort_busy", 32'(oBusy), 0);
    cmp("abort_cap", 32'(oCapture_En), 0);
    finish_frame();
    cmp("abort_pix", 32'(oPix_cnt), 2);
    cmp("abort_busy_end", 32'(oBusy), 0);
    expect_end("abort", 7, 0, 0, 1);
    start(0);
    partial_two_lines();
    iRST = 1'b1;
    tick();
    iRST = 1'b0;
    cmp("rst_mid_busy", 32'(oBusy), 0);
    cmp("rst_mid_cap", 32'(oCapture_En), 0);
    cmp("rst_mid_pix", 32'(oPix_cnt), 0);
    finish_frame();
    expect_end("rst_mid", 7, 0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
